// File: rtl/game_pkg.sv
// Shared game-level types: the round state encoding used by the sequencer,
// player, order and HUD blocks, plus default timing constants.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAYING   = 3'd2,
        PAUSED    = 3'd3,
        GAME_OVER = 3'd4
    } game_state_t;

    localparam logic [7:0]  ROUND_SECS = 8'd150;
    localparam logic [23:0] ONE_SEC_HW = 24'd10000000;

    // A round is "live" while playing or paused; the HUD warning only shows then.
    function automatic logic in_round(input game_state_t s);
        return (s == PLAYING) || (s == PAUSED);
    endfunction

endpackage

// File: rtl/sec_pulse_gen.sv
// Emits a one-cycle tick after every ONE_SEC enabled cycles.
// The count is held at 0 while clear is high, so each enable run starts fresh.
module sec_pulse_gen #(
    parameter logic [23:0] ONE_SEC = 24'd10
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    logic [23:0] sec_cnt;
    logic        at_end;

    assign at_end = (sec_cnt == ONE_SEC - 24'd1);
    assign tick   = enable && !clear && at_end;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sec_cnt <= 24'd0;
        end else if (clear) begin
            sec_cnt <= 24'd0;
        end else if (enable) begin
            sec_cnt <= at_end ? 24'd0 : sec_cnt + 24'd1;
        end
    end

endmodule

// File: rtl/game_round_ctrl.sv
// Round lifecycle sequencer: idle, 3-2-1 countdown, play, pause, game over.
// Drives the round timer's go/restart and feeds the HUD.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter logic [23:0] ONE_SEC        = 24'd10,
    parameter logic [1:0]  COUNTDOWN_SECS = 2'd3,
    parameter logic [7:0]  WARN_SECS      = 8'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [7:0] time_left,
    output logic       timer_go,
    output logic       timer_restart,
    output logic [2:0] state,
    output logic [1:0] countdown_val,
    output logic       low_time_warn,
    output logic       round_over
);

    game_state_t state_q, state_d;
    logic [1:0]  cd_q, cd_d;
    logic        sec_tick;
    logic        warn_d;
    logic        over_d;

    // Counter sits at 0 whenever we are outside the countdown, so every
    // entry (from IDLE or GAME_OVER) begins a full second.
    sec_pulse_gen #(
        .ONE_SEC (ONE_SEC)
    ) u_sec (
        .clock  (clock),
        .reset  (reset),
        .clear  (state_q != COUNTDOWN),
        .enable (state_q == COUNTDOWN),
        .tick   (sec_tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cd_q          <= 2'd0;
            low_time_warn <= 1'b0;
            round_over    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cd_q          <= cd_d;
            low_time_warn <= warn_d;
            round_over    <= over_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        case (state_q)
            IDLE: begin
                cd_d = 2'd0;
                if (start_btn) begin
                    state_d = COUNTDOWN;
                    cd_d    = COUNTDOWN_SECS;
                end
            end
            COUNTDOWN: begin
                if (sec_tick) begin
                    if (cd_q <= 2'd1) begin
                        state_d = PLAYING;
                        cd_d    = 2'd0;
                    end else begin
                        cd_d = cd_q - 2'd1;
                    end
                end
            end
            PLAYING: begin
                cd_d = 2'd0;
                // Expiry wins over a pause requested in the same cycle.
                if (time_left == 8'd0) begin
                    state_d = GAME_OVER;
                end else if (pause_btn) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                cd_d = 2'd0;
                if (start_btn) begin
                    state_d = IDLE;
                end else if (pause_btn) begin
                    state_d = PLAYING;
                end
            end
            GAME_OVER: begin
                cd_d = 2'd0;
                if (start_btn) begin
                    state_d = COUNTDOWN;
                    cd_d    = COUNTDOWN_SECS;
                end
            end
            default: begin
                state_d = IDLE;
                cd_d    = 2'd0;
            end
        endcase
    end

    assign warn_d = in_round(state_q) && (time_left != 8'd0) && (time_left <= WARN_SECS);
    assign over_d = (state_q == PLAYING) && (time_left == 8'd0);

    assign state         = state_q;
    assign countdown_val = cd_q;
    assign timer_go      = (state_q == PLAYING);
    assign timer_restart = (state_q == IDLE) || (state_q == COUNTDOWN);

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
Round-level sequencer for the kitchen game. Owns the round lifecycle: idle, 3-2-1 pre-round countdown, play, pause, game over. Drives the `timer_go` and `restart` inputs of the round timer, and watches its `time_left` output. Its state output gates player input, order generation and the HUD (countdown digits, low-time warning).

Parameters:
- ONE_SEC, 24'd10, clock cycles per second. Simulation value; hardware build overrides to 24'd10000000.
- COUNTDOWN_SECS, 2'd3, length of the pre-round countdown in seconds. Legal range 1..3.
- WARN_SECS, 8'd10, `low_time_warn` asserts when `time_left` <= this value.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_btn  in  1  single-cycle pulse, debounced upstream.
- pause_btn  in  1  single-cycle pulse, debounced upstream.
- time_left  in  8  seconds remaining, from the round timer.
- timer_go  out  1  to round timer: count enable.
- timer_restart  out  1  to round timer: reload full round time.
- state  out  3  current game_state_t.
- countdown_val  out  2  digit shown during countdown; 0 otherwise.
- low_time_warn  out  1  HUD warning flag.
- round_over  out  1  one-cycle pulse on entry to GAME_OVER.

Behaviour:
- Reset (async, any state): state=IDLE, sec_cnt=0, countdown_val=0, low_time_warn=0, round_over=0.
- Outputs are Moore decodes of the registered state. Exception: `round_over` and `low_time_warn` are registered directly.
- `timer_restart`=1 in IDLE and COUNTDOWN, 0 elsewhere. This holds the timer at full time until play begins.
- `timer_go`=1 only in PLAYING.
- Transition latency: an input pulse in cycle n produces the new state in cycle n+1.
- IDLE:
  - start_btn -> COUNTDOWN; countdown_val<=COUNTDOWN_SECS; sec_cnt<=0.
  - pause_btn ignored.
- COUNTDOWN:
  - sec_cnt increments every cycle.
  - At sec_cnt==ONE_SEC-1: sec_cnt<=0. If countdown_val==1 -> PLAYING with countdown_val<=0; otherwise countdown_val-1.
  - Total dwell is exactly COUNTDOWN_SECS*ONE_SEC cycles.
  - start_btn and pause_btn are ignored.
- PLAYING:
  - time_left==0 -> GAME_OVER, round_over=1 for exactly one cycle.
  - Else pause_btn -> PAUSED.
  - Expiry beats a simultaneous pause.
  - start_btn is ignored.
- PAUSED:
  - start_btn -> IDLE (abort round); this takes priority over pause_btn.
  - Else pause_btn -> PLAYING.
  - time_left is not checked while paused.
- GAME_OVER:
  - timer_go=0, timer_restart=0, so the display holds 0.
  - start_btn -> COUNTDOWN, loading countdown_val and clearing sec_cnt as in IDLE.
  - pause_btn ignored.
- low_time_warn:
  - Registered.
  - Next value = (state is PLAYING or PAUSED) && time_left!=0 && time_left<=WARN_SECS.
  - Is 0 in GAME_OVER.
- sec_cnt:
  - Width 24, clears on every entry to COUNTDOWN.
  - Holds 0 outside COUNTDOWN and never wraps past ONE_SEC-1.
- Illegal state encodings go to IDLE on the next clock.
- Reset mid-countdown or mid-play: immediate IDLE, timer_restart=1 on the following cycles.

Decomposition:
- Package `game_pkg` holds:
  - game_state_t: 3-bit enum with IDLE=0, COUNTDOWN=1, PLAYING=2, PAUSED=3, GAME_OVER=4. Shared with the player, order and HUD blocks.
  - Default constants ROUND_SECS=150 and ONE_SEC_HW=10000000.
- Sub-module `sec_pulse_gen`:
  - Inputs: clock, reset, clear, enable.
  - Output: a one-cycle tick every ONE_SEC enabled cycles.
  - Used for countdown sequencing; reusable by other per-second HUD logic.

Test Plan:
- Reset, then idle for 20 cycles -> state=0, timer_restart=1, timer_go=0, countdown_val=0.
- start_btn at cycle 5 (ONE_SEC=10, COUNTDOWN_SECS=3):
  - state=1 at cycle 6, countdown_val=3.
  - countdown_val goes 3,2,1 over 10-cycle steps.
  - state=2, timer_go=1, timer_restart=0 at cycle 36.
- In PLAYING, pause_btn -> state=3, timer_go=0. A second pause_btn -> state=2, timer_go=1. start_btn in PAUSED -> state=0.
- In PLAYING, drive time_left 11 -> 10 -> 1 -> 0:
  - low_time_warn is 0 at 11 and 1 at 10, staying 1 through 1.
  - At 0: state=4, round_over high exactly one cycle, low_time_warn=0.
- Simultaneous time_left==0 and pause_btn in PLAYING -> state=4, not 3. start_btn in GAME_OVER -> state=1, countdown_val=3.
- Assert reset mid-COUNTDOWN with countdown_val=2 -> state=0, countdown_val=0 asynchronously. After release, start_btn gives a full 30-cycle countdown.
